// File: rtl/fb_pixel_writer.sv
// Framebuffer write master: filters pixel results, buffers them in a FIFO and
// issues single-beat column-major writes (X*FB_HEIGHT+Y) on the SDRAM bridge.
module fb_pixel_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int FB_WIDTH   = 640,
  parameter int FB_HEIGHT  = 480,
  parameter int ADDR_W     = 19
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              PIX_VALID,
  output logic              PIX_READY,
  input  logic [15:0]       PIX_X,
  input  logic [15:0]       PIX_Y,
  input  logic [7:0]        PIX_I,
  output logic [ADDR_W-1:0] BR_ADDRESS,
  output logic [3:0]        BR_BYTE_EN,
  output logic              BR_WRITE,
  output logic [15:0]       BR_WRITE_DATA,
  input  logic              BR_ACK,
  input  logic              CLR_CNT,
  output logic              BUSY,
  output logic [19:0]       WR_COUNT,
  output logic [15:0]       DROP_COUNT
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENT_W = ADDR_W + 8;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state_reg;
  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [PTR_W:0]    count_reg;
  logic              ready_en_reg;

  logic              fifo_full;
  logic              fifo_empty;
  logic              pix_fire;
  logic              pix_in_range;
  logic              push;
  logic              pop;
  logic              wr_done;
  logic signed [31:0] x_s;
  logic signed [31:0] y_s;
  logic [ADDR_W-1:0] pix_addr;
  logic [ENT_W-1:0]  head;

  assign x_s = {{16{PIX_X[15]}}, PIX_X};
  assign y_s = {{16{PIX_Y[15]}}, PIX_Y};

  assign pix_in_range = (x_s >= 0) && (x_s < FB_WIDTH) &&
                        (y_s >= 0) && (y_s < FB_HEIGHT);
  // Product formed in 32 bits, then narrowed to the bridge address width.
  assign pix_addr = ADDR_W'(x_s * FB_HEIGHT + y_s);

  assign fifo_full  = (count_reg == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count_reg == '0);

  // ready_en_reg keeps the input closed until the first edge out of reset.
  assign PIX_READY = ready_en_reg && !fifo_full;
  assign pix_fire  = PIX_VALID && PIX_READY;
  assign push      = pix_fire && pix_in_range;
  assign wr_done   = (state_reg == WRITE) && BR_ACK;
  assign pop       = !fifo_empty && ((state_reg == IDLE) || BR_ACK);
  assign head      = fifo_mem[rd_ptr_reg];

  assign BR_BYTE_EN = 4'b0011;
  assign BUSY       = !fifo_empty || BR_WRITE;

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {pix_addr, PIX_I};
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (push && !pop) begin
        count_reg <= count_reg + 1'b1;
      end else if (pop && !push) begin
        count_reg <= count_reg - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg     <= IDLE;
      BR_WRITE      <= 1'b0;
      BR_ADDRESS    <= '0;
      BR_WRITE_DATA <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (pop) begin
            BR_ADDRESS    <= head[ENT_W-1:8];
            BR_WRITE_DATA <= {8'h00, head[7:0]};
            BR_WRITE      <= 1'b1;
            state_reg     <= WRITE;
          end
        end
        WRITE: begin
          if (BR_ACK) begin
            if (pop) begin
              BR_ADDRESS    <= head[ENT_W-1:8];
              BR_WRITE_DATA <= {8'h00, head[7:0]};
            end else begin
              BR_WRITE  <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          BR_WRITE  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      WR_COUNT   <= '0;
      DROP_COUNT <= '0;
    end else if (CLR_CNT) begin
      WR_COUNT   <= '0;
      DROP_COUNT <= '0;
    end else begin
      if (wr_done && !(&WR_COUNT)) begin
        WR_COUNT <= WR_COUNT + 1'b1;
      end
      if (pix_fire && !pix_in_range && !(&DROP_COUNT)) begin
        DROP_COUNT <= DROP_COUNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Scoreboard bench for fb_pixel_writer: directed boundary/backpressure/reset
// scenarios followed by randomized pixels against a queue-based model.
module tb_fb_pixel_writer;

  logic        CLK;
  logic        RESET_N;
  logic        PIX_VALID;
  logic        PIX_READY;
  logic [15:0] PIX_X;
  logic [15:0] PIX_Y;
  logic [7:0]  PIX_I;
  logic [18:0] BR_ADDRESS;
  logic [3:0]  BR_BYTE_EN;
  logic        BR_WRITE;
  logic [15:0] BR_WRITE_DATA;
  logic        BR_ACK;
  logic        CLR_CNT;
  logic        BUSY;
  logic [19:0] WR_COUNT;
  logic [15:0] DROP_COUNT;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t sb[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   acc_exp  = 0;
  int   drop_exp = 0;
  int   ack_mode = 0;

  fb_pixel_writer dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .PIX_VALID    (PIX_VALID),
    .PIX_READY    (PIX_READY),
    .PIX_X        (PIX_X),
    .PIX_Y        (PIX_Y),
    .PIX_I        (PIX_I),
    .BR_ADDRESS   (BR_ADDRESS),
    .BR_BYTE_EN   (BR_BYTE_EN),
    .BR_WRITE     (BR_WRITE),
    .BR_WRITE_DATA(BR_WRITE_DATA),
    .BR_ACK       (BR_ACK),
    .CLR_CNT      (CLR_CNT),
    .BUSY         (BUSY),
    .WR_COUNT     (WR_COUNT),
    .DROP_COUNT   (DROP_COUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #10 CLK = ~CLK;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Present one pixel from a negedge; the model records it only when the DUT
  // shows ready, i.e. when the following rising edge will accept it.
  task automatic send_px(input int x, input int y, input int i, input int bound,
                         output bit acc);
    exp_t e;
    PIX_X     = 16'(x);
    PIX_Y     = 16'(y);
    PIX_I     = 8'(i);
    PIX_VALID = 1'b1;
    acc       = 1'b0;
    for (int n = 0; n < bound && !acc; n++) begin
      if (PIX_READY) begin
        acc = 1'b1;
        if (x >= 0 && x < 640 && y >= 0 && y < 480) begin
          e.addr = x * 480 + y;
          e.data = i & 255;
          sb.push_back(e);
          acc_exp++;
        end else begin
          drop_exp++;
        end
      end
      @(negedge CLK);
    end
    PIX_VALID = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((BUSY || sb.size() != 0) && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk({name, "_busy"}, BUSY, 0);
    chk({name, "_sb_left"}, sb.size(), 0);
  endtask

  // Bridge acknowledge generator: low, high, or random per cycle.
  initial begin
    BR_ACK = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (ack_mode == 0)      BR_ACK = 1'b0;
      else if (ack_mode == 1) BR_ACK = 1'b1;
      else                    BR_ACK = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: every write accepted by the bridge must match the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RESET_N && BR_WRITE && BR_ACK) begin
        if (sb.size() == 0) begin
          chk_cnt++;
          $display("FAIL wr_unexpected: got write to addr %0d, expected no write", BR_ADDRESS);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", BR_ADDRESS, e.addr);
          chk("wr_data", BR_WRITE_DATA, e.data);
          chk("wr_byte_en", BR_BYTE_EN, 3);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected summary before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;
    int x;
    int y;
    int i;
    int bx[4];
    int by[4];
    bx = '{-1, 640, 0, 0};
    by = '{0, 0, 480, -3};

    RESET_N   = 1'b0;
    PIX_VALID = 1'b0;
    PIX_X     = '0;
    PIX_Y     = '0;
    PIX_I     = '0;
    CLR_CNT   = 1'b0;

    repeat (2) @(negedge CLK);
    chk("rst_ready", PIX_READY, 0);
    chk("rst_write", BR_WRITE, 0);
    chk("rst_addr", BR_ADDRESS, 0);
    chk("rst_data", BR_WRITE_DATA, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_wrcnt", WR_COUNT, 0);
    chk("rst_dropcnt", DROP_COUNT, 0);
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("ready_after_rst", PIX_READY, 1);

    // Single pixel with a delayed acknowledge
    send_px(2, 5, 77, 4, acc);
    chk("single_acc", acc, 1);
    chk("single_lat_write", BR_WRITE, 0);
    chk("single_lat_busy", BUSY, 1);
    @(negedge CLK);
    chk("single_write", BR_WRITE, 1);
    chk("single_addr", BR_ADDRESS, 965);
    chk("single_data", BR_WRITE_DATA, 16'h004D);
    chk("single_byte_en", BR_BYTE_EN, 4'b0011);
    repeat (2) begin
      @(negedge CLK);
      chk("single_hold_write", BR_WRITE, 1);
      chk("single_hold_addr", BR_ADDRESS, 965);
    end
    ack_mode = 1;
    @(negedge CLK);
    ack_mode = 0;
    @(negedge CLK);
    chk("single_write_drop", BR_WRITE, 0);
    chk("single_wrcnt", WR_COUNT, 1);
    chk("single_busy_end", BUSY, 0);

    // Boundaries: far corner written, four out-of-range pixels dropped
    ack_mode = 1;
    send_px(639, 479, 200, 4, acc);
    chk("corner_acc", acc, 1);
    for (int k = 0; k < 4; k++) begin
      send_px(bx[k], by[k], k, 4, acc);
      chk("drop_acc", acc, 1);
      chk("drop_ready", PIX_READY, 1);
    end
    drain("bound");
    chk("drop_cnt", DROP_COUNT, drop_exp);
    chk("bound_wrcnt", WR_COUNT, acc_exp);

    // Backpressure: bridge stalled, output register plus FIFO fill up
    ack_mode = 0;
    @(negedge CLK);
    n = 0;
    for (int k = 0; k < 9; k++) begin
      send_px($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 255), 4, acc);
      n += int'(acc);
    end
    chk("bp_accepted", n, 9);
    chk("bp_ready_low", PIX_READY, 0);
    chk("bp_write_held", BR_WRITE, 1);
    send_px($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 255), 3, acc);
    chk("bp_blocked", acc, 0);
    ack_mode = 1;
    n = 0;
    @(negedge CLK);
    while (BR_WRITE && BR_ACK && n < 50) begin
      n++;
      @(negedge CLK);
    end
    chk("bp_b2b_writes", n, 9);
    chk("bp_ready_back", PIX_READY, 1);

    // Full FIFO with a pop on the same edge: push must still wait a cycle
    ack_mode = 0;
    @(negedge CLK);
    n = 0;
    for (int k = 0; k < 9; k++) begin
      send_px($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 255), 4, acc);
      n += int'(acc);
    end
    chk("fp_fill", n, 9);
    chk("fp_ready_low", PIX_READY, 0);
    x = int'($urandom_range(0, 639));
    y = int'($urandom_range(0, 479));
    i = int'($urandom_range(0, 255));
    PIX_X     = 16'(x);
    PIX_Y     = 16'(y);
    PIX_I     = 8'(i);
    PIX_VALID = 1'b1;
    ack_mode  = 1;
    @(negedge CLK);
    chk("fp_blocked_on_pop", PIX_READY, 0);
    ack_mode = 0;
    send_px(x, y, i, 4, acc);
    chk("fp_next_acc", acc, 1);
    chk("fp_full_again", PIX_READY, 0);
    ack_mode = 1;
    drain("fp");

    // Reset in the middle of a queued burst
    ack_mode = 0;
    @(negedge CLK);
    send_px(-5, 10, 1, 4, acc);
    for (int k = 0; k < 4; k++) begin
      send_px($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 255), 4, acc);
    end
    chk("rm_write_up", BR_WRITE, 1);
    chk("rm_busy_up", BUSY, 1);
    RESET_N = 1'b0;
    #1;
    chk("rm_write_async", BR_WRITE, 0);
    chk("rm_busy", BUSY, 0);
    chk("rm_ready", PIX_READY, 0);
    chk("rm_wrcnt", WR_COUNT, 0);
    chk("rm_dropcnt", DROP_COUNT, 0);
    sb.delete();
    acc_exp  = 0;
    drop_exp = 0;
    repeat (2) @(negedge CLK);
    RESET_N  = 1'b1;
    ack_mode = 1;
    n = 0;
    repeat (10) begin
      @(negedge CLK);
      if (BR_WRITE) n++;
    end
    chk("rm_no_write", n, 0);
    chk("rm_ready_back", PIX_READY, 1);
    chk("rm_busy_idle", BUSY, 0);

    // Counter clear on the same edge as an acknowledge
    ack_mode = 0;
    @(negedge CLK);
    send_px(-1, -1, 0, 4, acc);
    send_px($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 255), 4, acc);
    @(negedge CLK);
    chk("clr_write_up", BR_WRITE, 1);
    chk("clr_drop_before", DROP_COUNT, 1);
    ack_mode = 1;
    @(negedge CLK);
    CLR_CNT  = 1'b1;
    ack_mode = 0;
    @(negedge CLK);
    CLR_CNT = 1'b0;
    chk("clr_wrcnt", WR_COUNT, 0);
    chk("clr_dropcnt", DROP_COUNT, 0);
    chk("clr_write_done", BR_WRITE, 0);
    acc_exp  = 0;
    drop_exp = 0;

    // Randomized traffic with a random bridge acknowledge
    ack_mode = 2;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 3) == 0) @(negedge CLK);
      x = int'($urandom_range(0, 679)) - 20;
      y = int'($urandom_range(0, 519)) - 20;
      send_px(x, y, $urandom_range(0, 255), 300, acc);
      chk("rnd_acc", acc, 1);
    end
    drain("rnd");
    chk("rnd_wrcnt", WR_COUNT, acc_exp);
    chk("rnd_dropcnt", DROP_COUNT, drop_exp);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
